halt_monitor: RTL and testbench

- Sits between the simple CPU's retire/writeback stage and the simulation cycle counter; produces the counter's halt strobe and return value.
- Watches the retire stream for the halt instruction.
- Shadows the architectural return register from writeback traffic.
- Waits for outstanding memory activity to drain, then raises is_halt with the captured value.

---
 rtl/halt_monitor_pkg.sv | 25 ++
 rtl/halt_monitor_drain_timer.sv | 37 +++
 rtl/halt_monitor.sv | 112 +++++++++++
 tb/tb_halt_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_monitor_pkg.sv
// rtl/halt_monitor_pkg.sv - shared types and default constants for the halt monitor
package halt_monitor_pkg;

  // Monitor lifecycle: running the program, draining memory, finished
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int          REG_IDX_W        = 3;
  localparam logic [15:0] HALT_INSTR_DEF   = 16'hF000;
  localparam logic [REG_IDX_W-1:0] RET_REG_DEF = 3'd3;
  localparam int          DRAIN_CYCLES_DEF = 4;
  localparam int          LOOP_LIMIT_DEF   = 8;

  // Bits needed to hold values 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/halt_monitor_drain_timer.sv
// rtl/halt_monitor_drain_timer.sv - drain countdown with reload while memory is busy
module drain_timer
  import halt_monitor_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic busy,
  output logic done
);

  localparam int          W      = cnt_width(DRAIN_CYCLES);
  localparam logic [W-1:0] RELOAD = W'(DRAIN_CYCLES);

  logic [W-1:0] count;

  // Load on halt; while running, busy restarts the window so idle cycles must be consecutive
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (run) begin
      if (busy) begin
        count <= RELOAD;
      end else if (count != '0) begin
        count <= count - W'(1);
      end
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/halt_monitor.sv
// rtl/halt_monitor.sv - retire-stream halt detector with return-value shadow; option SELF_LOOP_HALT_EN
module halt_monitor
  import halt_monitor_pkg::*;
#(
  parameter logic [15:0]          HALT_INSTR   = HALT_INSTR_DEF,
  parameter logic [REG_IDX_W-1:0] RET_REG      = RET_REG_DEF,
  parameter int                   DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int                   LOOP_LIMIT   = LOOP_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 retire_valid,
  input  logic [15:0]          retire_instr,
  input  logic [15:0]          retire_pc,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [15:0]          wb_data,
  input  logic                 mem_busy,
  output logic                 is_halt,
  output logic [15:0]          ret_val,
  output logic [31:0]          retired_count
);

  state_t      state;
  logic [15:0] shadow;
  logic        halt_hit;
  logic        loop_hit;
  logic        start_drain;
  logic        drain_done;

  assign halt_hit    = retire_valid && (retire_instr == HALT_INSTR);
  assign start_drain = (state == RUN) && (halt_hit || loop_hit);

`ifdef SELF_LOOP_HALT_EN
  localparam int              RUN_W     = cnt_width(LOOP_LIMIT);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOOP_LIMIT);

  logic [15:0]      last_pc;
  logic             pc_seen;
  logic [RUN_W-1:0] run_len;
  logic             same_pc;

  // The very first retire after reset has nothing to repeat
  assign same_pc  = retire_valid && pc_seen && (retire_pc == last_pc);
  assign loop_hit = same_pc && ((int'(run_len) + 1) >= LOOP_LIMIT);

  // Run length of back-to-back retires at one PC, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc <= '0;
      pc_seen <= 1'b0;
      run_len <= '0;
    end else if (retire_valid) begin
      last_pc <= retire_pc;
      pc_seen <= 1'b1;
      if (same_pc) begin
        if (run_len != RUN_LIMIT) run_len <= run_len + RUN_W'(1);
      end else begin
        run_len <= '0;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^retire_pc;
  assign loop_hit  = 1'b0;
`endif

  drain_timer #(
    .DRAIN_CYCLES(DRAIN_CYCLES)
  ) u_drain_timer (
    .clk  (clk),
    .rst  (rst),
    .load (start_drain),
    .run  (state == DRAIN),
    .busy (mem_busy),
    .done (drain_done)
  );

  // Lifecycle FSM with registered outputs; writebacks after the halt belong to squashed instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      is_halt       <= 1'b0;
      ret_val       <= '0;
      retired_count <= '0;
      shadow        <= '0;
    end else begin
      case (state)
        RUN: begin
          if (wb_en && (wb_addr == RET_REG)) shadow <= wb_data;
          if (retire_valid) retired_count <= retired_count + 32'd1;
          if (start_drain) state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            state   <= HALTED;
            is_halt <= 1'b1;
            ret_val <= shadow;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_halt_monitor.sv
// tb/tb_halt_monitor.sv - scoreboard bench for halt_monitor against a behavioural model
module tb_halt_monitor;

  localparam logic [15:0] HALT = 16'hF000;
  localparam int          RETR = 3;
  localparam int          DC   = 4;
  localparam int          LL   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [15:0] retire_instr = '0;
  logic [15:0] retire_pc = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        mem_busy = 1'b0;
  logic        is_halt;
  logic [15:0] ret_val;
  logic [31:0] retired_count;

  halt_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .retire_valid  (retire_valid),
    .retire_instr  (retire_instr),
    .retire_pc     (retire_pc),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .mem_busy      (mem_busy),
    .is_halt       (is_halt),
    .ret_val       (ret_val),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [15:0] ret;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_no = 0;
  int   last_rise = -1;
  logic prev_halt = 1'b0;

  // Model: program-level view of the monitor
  bit          m_draining, m_halted, m_have_pc;
  int          m_idle, m_rep;
  logic [15:0] m_shadow, m_ret, m_last_pc;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic model_step();
    bit loop_fire;
    if (rst) begin
      m_draining = 0; m_halted = 0; m_have_pc = 0;
      m_idle = 0; m_rep = 0;
      m_shadow = '0; m_ret = '0; m_last_pc = '0; m_count = '0;
      return;
    end
    if (retire_valid) begin
      if (m_have_pc && retire_pc == m_last_pc) begin
        if (m_rep < LL) m_rep++;
      end else begin
        m_rep = 0;
      end
      m_last_pc = retire_pc;
      m_have_pc = 1;
    end
`ifdef SELF_LOOP_HALT_EN
    loop_fire = retire_valid && (m_rep == LL);
`else
    loop_fire = 0;
`endif
    if (m_halted) begin
    end else if (m_draining) begin
      if (m_idle >= DC) begin
        m_halted = 1;
        m_ret = m_shadow;
        q.push_back('{edge_no, m_shadow, m_count});
      end else begin
        m_idle = mem_busy ? 0 : m_idle + 1;
      end
    end else begin
      if (wb_en && wb_addr == RETR) m_shadow = wb_data;
      if (retire_valid) begin
        m_count = m_count + 32'd1;
        if (retire_instr == HALT || loop_fire) begin
          m_draining = 1;
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_step();
    #1;
  endtask

  task automatic drive(input logic rv, input logic [15:0] ins, input logic [15:0] pc,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic busy);
    retire_valid = rv; retire_instr = ins; retire_pc = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; mem_busy = busy;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic sb_drained(input string name);
    check(name, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] x;
    x = 16'($urandom);
    while (x == HALT) x = 16'($urandom);
    return x;
  endfunction

  // Monitor: per-cycle state checks and scoreboard pop on every is_halt rise
  always @(negedge clk) begin
    if (edge_no > 0) begin
      check("is_halt", 64'(is_halt), 64'(m_halted));
      check("ret_val", 64'(ret_val), m_halted ? 64'(m_ret) : 64'd0);
      check("retired_count", 64'(retired_count), 64'(m_count));
      if (is_halt && !prev_halt) begin
        last_rise = edge_no;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_halt: is_halt=1 expected 0 (edge %0d)", edge_no);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("halt_edge", 64'(edge_no), 64'(e.edge_no));
          check("halt_ret", 64'(ret_val), 64'(e.ret));
          check("halt_count", 64'(retired_count), 64'(e.cnt));
        end
      end
      prev_halt = is_halt;
    end
  end

  initial begin
    int h;
    #1;
    do_reset();
    check("reset_is_halt", 64'(is_halt), 64'd0);
    check("reset_ret_val", 64'(ret_val), 64'd0);
    check("reset_count", 64'(retired_count), 64'd0);

    // Basic program: r3=0x2A, 5 retires, halt
    drive(0, 16'h0, 16'h0, 1, 3'd3, 16'h002A, 0);
    for (int i = 0; i < 5; i++) drive(1, 16'h1000 + 16'(i), 16'h0010 + 16'(i), 0, 0, 0, 0);
    drive(1, HALT, 16'h0020, 0, 0, 0, 0);
    h = edge_no;
    idle(10);
    check("t1_latency", 64'(last_rise - h), 64'd5);
    check("t1_ret", 64'(ret_val), 64'h002A);
    check("t1_count", 64'(retired_count), 64'd6);
    sb_drained("t1_sb_empty");

    // Busy interrupts the drain after two idle cycles
    do_reset();
    drive(1, HALT, 16'h0000, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) drive(0, 16'h0, 16'h0, 0, 0, 0, 1);
    h = edge_no;
    idle(10);
    check("t2_latency", 64'(last_rise - h), 64'd5);
    sb_drained("t2_sb_empty");

    // Same-cycle writeback is kept; writeback during drain is ignored
    do_reset();
    drive(1, HALT, 16'h0004, 1, 3'd3, 16'h0007, 0);
    drive(0, 16'h0, 16'h0, 1, 3'd3, 16'h0009, 0);
    idle(10);
    check("t3_ret", 64'(ret_val), 64'h0007);
    sb_drained("t3_sb_empty");

    // Writeback to a different register only
    do_reset();
    drive(0, 16'h0, 16'h0, 1, 3'd2, 16'h1234, 0);
    drive(1, HALT, 16'h0002, 0, 0, 0, 0);
    idle(10);
    check("t4_ret", 64'(ret_val), 64'h0000);
    check("t4_halt", 64'(is_halt), 64'd1);
    sb_drained("t4_sb_empty");

    // Reset mid-drain, then a fresh program
    do_reset();
    drive(0, 16'h0, 16'h0, 1, 3'd3, 16'h00AA, 0);
    drive(1, HALT, 16'h0001, 0, 0, 0, 0);
    idle(2);
    do_reset();
    idle(8);
    check("t5_no_halt", 64'(is_halt), 64'd0);
    drive(1, 16'h2222, 16'h0008, 1, 3'd3, 16'h0001, 0);
    drive(1, HALT, 16'h000A, 0, 0, 0, 0);
    idle(10);
    check("t5_ret", 64'(ret_val), 64'h0001);
    sb_drained("t5_sb_empty");

    // Nine retires at one PC
    do_reset();
    for (int i = 0; i < 9; i++) drive(1, 16'h1111, 16'h0040, 0, 0, 0, 0);
    h = edge_no;
    idle(10);
`ifdef SELF_LOOP_HALT_EN
    check("t6_loop_halt", 64'(is_halt), 64'd1);
    check("t6_latency", 64'(last_rise - h), 64'd5);
`else
    check("t6_no_loop_halt", 64'(is_halt), 64'd0);
`endif
    check("t6_count", 64'(retired_count), 64'd9);
    sb_drained("t6_sb_empty");

    // Random programs
    for (int p = 0; p < 24; p++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        logic [15:0] ins;
        logic [15:0] pc;
        ins = ($urandom_range(0, 24) == 0) ? HALT : rnd_instr();
        pc  = (p % 2 == 1) ? 16'($urandom_range(0, 1)) : 16'($urandom);
        rst = ($urandom_range(0, 99) == 0);
        drive(1'($urandom), ins, pc, 1'($urandom), 3'($urandom), 16'($urandom),
              ($urandom_range(0, 3) == 0));
      end
      rst = 1'b0;
      idle(10);
      sb_drained("rand_sb_empty");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
